// File: rtl/pcf8563_time_sync.sv
// pcf8563_time_sync: polls the PCF8563 seconds register, validates/decodes the BCD
// byte and publishes a seconds + sub-second cycle-count timestamp.
module pcf8563_time_sync #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int POLL_CYCLES    = 100_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int SUBW           = $clog2(CLK_FREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            start,
    input  logic [7:0]      rdata,
    input  logic            done,
    output logic [5:0]      sec,
    output logic [SUBW-1:0] subsec,
    output logic            sec_valid,
    output logic            sec_tick,
    output logic            vl,
    output logic            err,
    output logic            fault
);
    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SUBW-1:0] SUB_MAX   = SUBW'(CLK_FREQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BUSY, S_CHECK} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] to_cnt;
    logic          done_p0;
    logic [7:0]    rdata_p0;
    logic          err_p1;

    logic       timeout_hit, chk_ok, chk_bad, first_smp, sec_chg, idle_off;
    logic [5:0] value;

    function automatic logic bcd_ok(input logic [6:0] b);
        return (b[6:4] <= 3'd5) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [5:0] bcd_to_bin(input logic [6:0] b);
        return ({3'b000, b[6:4]} * 6'd10) + {2'b00, b[3:0]};
    endfunction

    always_comb begin
        value       = bcd_to_bin(rdata_p0[6:0]);
        timeout_hit = (state_q == S_BUSY) && !done_p0 && (to_cnt == TO_LAST);
        chk_ok      = (state_q == S_CHECK) && bcd_ok(rdata_p0[6:0]);
        chk_bad     = (state_q == S_CHECK) && !bcd_ok(rdata_p0[6:0]);
        first_smp   = chk_ok && !sec_valid;
        sec_chg     = chk_ok && sec_valid && (value != sec);
        idle_off    = (state_q == S_IDLE) && !en;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_WAIT;
            S_WAIT: begin
                if (!en)                        state_d = S_IDLE;
                else if (poll_cnt == POLL_LAST) state_d = S_REQ;
            end
            S_REQ:   state_d = S_BUSY;
            S_BUSY: begin
                // A falling en never aborts a read; it only redirects the exit.
                if (done_p0)          state_d = S_CHECK;
                else if (timeout_hit) state_d = en ? S_WAIT : S_IDLE;
            end
            S_CHECK: state_d = en ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start = (state_q == S_REQ);
    // Timeout err is decoded during the last BUSY cycle; check err is registered.
    assign err   = err_p1 | timeout_hit;

    // Input capture stage: done/rdata only accepted while a read is outstanding
    always_ff @(posedge clk) begin
        if ((state_q == S_BUSY) && done) rdata_p0 <= rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            poll_cnt  <= '0;
            to_cnt    <= '0;
            done_p0   <= 1'b0;
            err_p1    <= 1'b0;
            sec_tick  <= 1'b0;
            fault     <= 1'b0;
            sec_valid <= 1'b0;
            sec       <= '0;
            vl        <= 1'b0;
            subsec    <= '0;
        end else begin
            state_q  <= state_d;
            poll_cnt <= ((state_q == S_WAIT) && (state_d == S_WAIT)) ? poll_cnt + PW'(1) : '0;
            to_cnt   <= (state_q == S_BUSY) ? to_cnt + TW'(1) : '0;
            done_p0  <= (state_q == S_BUSY) && done;
            // Check/publish stage
            err_p1   <= chk_bad;
            sec_tick <= sec_chg;
            if (chk_bad || timeout_hit) fault <= 1'b1;
            else if (idle_off)          fault <= 1'b0;
            if (first_smp)     sec_valid <= 1'b1;
            else if (idle_off) sec_valid <= 1'b0;
            if (chk_ok) begin
                sec <= value;
                vl  <= rdata_p0[7];
            end
            if (first_smp || sec_chg || (state_q == S_IDLE)) subsec <= '0;
            else if (sec_valid && (subsec != SUB_MAX))        subsec <= subsec + SUBW'(1);
        end
    end
endmodule

// File: tb/tb_pcf8563_time_sync.sv
// Randomized self-checking bench for pcf8563_time_sync with a spec-level model
// of the seconds tracker and an emulated PCF8563 interface answering start.
`timescale 1ns/1ps
module tb_pcf8563_time_sync;
    localparam int CLK_FREQ       = 1000;
    localparam int POLL_CYCLES    = 100;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int SUBW           = $clog2(CLK_FREQ);
    localparam int DONE_DLY       = 20;

    logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0, done = 1'b0;
    logic [7:0]      rdata = 8'h00;
    logic            start, sec_valid, sec_tick, vl, err, fault;
    logic [5:0]      sec;
    logic [SUBW-1:0] subsec;

    pcf8563_time_sync #(
        .CLK_FREQ(CLK_FREQ), .POLL_CYCLES(POLL_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SUBW(SUBW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .rdata(rdata), .done(done),
        .sec(sec), .subsec(subsec), .sec_valid(sec_valid), .sec_tick(sec_tick),
        .vl(vl), .err(err), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int cyc = 0, tick_cnt = 0, err_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sec_tick === 1'b1) tick_cnt <= tick_cnt + 1;
        if (err === 1'b1)      err_cnt  <= err_cnt + 1;
    end

    // Reference model state
    int m_sec = 0, m_vl = 0, m_ticks = 0, m_errs = 0, m_clear = 0;
    bit m_valid = 0, m_fault = 0;
    // Snapshot of one read
    logic [5:0] s_sec, e_sec;
    logic       s_valid, s_vl, s_tick, s_err, s_fault, e_valid;
    int         s_sub, s_xsub;
    bit         x_tick, x_err;

    function automatic int exp_sub();
        int d;
        if (!m_valid) return 0;
        d = cyc - m_clear;
        return (d > CLK_FREQ - 1) ? CLK_FREQ - 1 : d;
    endfunction

    task automatic model_read(input logic [7:0] v, output bit clr, output bit tk, output bit bad);
        int t, u, val;
        t = int'(v[6:4]); u = int'(v[3:0]); val = t * 10 + u;
        clr = 0; tk = 0; bad = 0;
        if (t > 5 || u > 9) begin
            bad = 1; m_errs++; m_fault = 1;
        end else begin
            m_vl = int'(v[7]);
            if (!m_valid) begin m_sec = val; m_valid = 1; clr = 1; end
            else if (val != m_sec) begin m_sec = val; m_ticks++; tk = 1; clr = 1; end
        end
    endtask

    task automatic wait_start(output int n, output bit ok);
        n = 0; ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1; n++;
            if (start === 1'b1) begin ok = 1; break; end
        end
    endtask

    // Called just after the edge that raised start; returns after the update edge.
    task automatic give_done(input logic [7:0] v);
        bit clr;
        repeat (DONE_DLY - 1) @(posedge clk);
        #1 done = 1'b1; rdata = v;
        @(posedge clk); #1 done = 1'b0; rdata = 8'hFF;
        @(posedge clk); #1 e_valid = sec_valid; e_sec = sec;
        @(posedge clk); #1;
        s_sec = sec; s_valid = sec_valid; s_vl = vl; s_tick = sec_tick;
        s_err = err; s_fault = fault; s_sub = int'(subsec);
        model_read(v, clr, x_tick, x_err);
        if (clr) m_clear = cyc;
        s_xsub = exp_sub();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if ({start, sec_valid, sec_tick, vl, err, fault} !== 6'b0) begin fails++; $display("FAIL reset_flags: got %b want 000000", {start, sec_valid, sec_tick, vl, err, fault}); end
        checks++; if (sec !== 6'd0) begin fails++; $display("FAIL reset_sec: got %0d want 0", sec); end
        checks++; if (subsec !== '0) begin fails++; $display("FAIL reset_subsec: got %0d want 0", subsec); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++; if (start !== 1'b0) begin fails++; $display("FAIL idle_start: got %b want 0", start); end
    endtask

    task automatic test_first_start();
        int n; bit ok;
        @(posedge clk); #1 en = 1'b1;
        wait_start(n, ok);
        checks++; if (!ok || n != POLL_CYCLES + 1) begin fails++; $display("FAIL first_start_latency: got %0d want %0d", n, POLL_CYCLES + 1); end
        checks++; if ({sec_valid, sec_tick, vl, err, fault, sec, subsec} !== '0) begin fails++; $display("FAIL pre_check_outputs: got nonzero want all 0"); end
        give_done(8'h25);
        checks++; if (e_valid !== 1'b0) begin fails++; $display("FAIL update_latency: sec_valid %b one edge early, want 0", e_valid); end
        checks++; if (s_sec !== 6'(m_sec) || s_valid !== 1'b1) begin fails++; $display("FAIL first_sample: sec %0d valid %b want %0d 1", s_sec, s_valid, m_sec); end
        checks++; if (s_tick !== 1'b0 || s_sub != 0) begin fails++; $display("FAIL first_no_tick: tick %b subsec %0d want 0 0", s_tick, s_sub); end
    endtask

    task automatic test_seconds();
        int n, t0; bit ok;
        t0 = tick_cnt;
        wait_start(n, ok);
        // Counted from the update edge, which is one edge after CHECK.
        checks++; if (!ok || n != POLL_CYCLES) begin fails++; $display("FAIL poll_period: got %0d want %0d", n, POLL_CYCLES); end
        give_done(8'h25);
        checks++; if (s_sec !== 6'd25 || s_tick !== 1'b0 || tick_cnt != t0) begin fails++; $display("FAIL same_value: sec %0d ticks %0d want 25 0", s_sec, tick_cnt - t0); end
        checks++; if (s_sub != s_xsub) begin fails++; $display("FAIL subsec_count: got %0d want %0d", s_sub, s_xsub); end
        wait_start(n, ok);
        give_done(8'h26);
        checks++; if (s_sec !== 6'd26 || s_tick !== 1'b1 || tick_cnt != t0 + 1) begin fails++; $display("FAIL change_tick: sec %0d ticks %0d want 26 1", s_sec, tick_cnt - t0); end
        checks++; if (s_sub != 0) begin fails++; $display("FAIL tick_subsec: got %0d want 0", s_sub); end
    endtask

    task automatic test_wrap();
        int n; bit ok;
        wait_start(n, ok); give_done(8'h59);
        wait_start(n, ok); give_done(8'h00);
        checks++; if (s_sec !== 6'd0 || s_tick !== 1'b1) begin fails++; $display("FAIL wrap_59_0: sec %0d tick %b want 0 1", s_sec, s_tick); end
        wait_start(n, ok); give_done(8'h85);
        checks++; if (s_sec !== 6'd5 || s_vl !== 1'b1 || s_valid !== 1'b1) begin fails++; $display("FAIL vl_sample: sec %0d vl %b valid %b want 5 1 1", s_sec, s_vl, s_valid); end
        checks++; if (tick_cnt != m_ticks) begin fails++; $display("FAIL tick_total: got %0d want %0d", tick_cnt, m_ticks); end
    endtask

    task automatic test_invalid();
        int n, e0; bit ok;
        e0 = err_cnt;
        wait_start(n, ok); give_done(8'h6A);
        checks++; if (s_err !== 1'b1 || s_fault !== 1'b1) begin fails++; $display("FAIL bad_tens: err %b fault %b want 1 1", s_err, s_fault); end
        wait_start(n, ok); give_done(8'h3C);
        checks++; if (err_cnt != e0 + 2) begin fails++; $display("FAIL err_pulses: got %0d want 2", err_cnt - e0); end
        checks++; if (s_sec !== 6'd5 || s_vl !== 1'b1 || s_valid !== 1'b1) begin fails++; $display("FAIL bad_holds: sec %0d vl %b valid %b want 5 1 1", s_sec, s_vl, s_valid); end
        en = 1'b0;
        repeat (3) @(posedge clk); #1;
        m_valid = 0; m_fault = 0;
        checks++; if (fault !== 1'b0 || sec_valid !== 1'b0 || subsec !== '0) begin fails++; $display("FAIL idle_clear: fault %b valid %b subsec %0d want 0 0 0", fault, sec_valid, subsec); end
    endtask

    task automatic test_timeout();
        int n, e0; bit ok, seen;
        e0 = err_cnt;
        @(posedge clk); #1 en = 1'b1;
        wait_start(n, ok);
        n = 0; seen = 0;
        for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++) begin
            @(posedge clk); #1; n++;
            if (err === 1'b1) begin seen = 1; break; end
        end
        checks++; if (!seen || n != TIMEOUT_CYCLES) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT_CYCLES); end
        m_errs++; m_fault = 1;
        @(posedge clk); #1;
        checks++; if (fault !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL timeout_fault: fault %b err %b want 1 0", fault, err); end
        done = 1'b1; rdata = 8'h11;
        @(posedge clk); #1 done = 1'b0; rdata = 8'hFF;
        wait_start(n, ok);
        checks++; if (!ok || n + 2 != POLL_CYCLES + 1) begin fails++; $display("FAIL timeout_next_start: got %0d want %0d", n + 2, POLL_CYCLES + 1); end
        checks++; if (sec !== 6'(m_sec) || sec_valid !== 1'b0 || err_cnt != e0 + 1) begin fails++; $display("FAIL stray_done: sec %0d valid %b errs %0d want %0d 0 1", sec, sec_valid, err_cnt - e0, m_sec); end
        give_done(8'h30);
        checks++; if (s_sec !== 6'd30 || s_tick !== 1'b0 || s_valid !== 1'b1) begin fails++; $display("FAIL after_timeout: sec %0d tick %b valid %b want 30 0 1", s_sec, s_tick, s_valid); end
    endtask

    task automatic test_saturate();
        int n, t0; bit ok;
        t0 = tick_cnt;
        for (int i = 0; i < 17; i++) begin
            wait_start(n, ok); give_done(8'h30);
        end
        checks++; if (s_sub != CLK_FREQ - 1 || s_sub != s_xsub) begin fails++; $display("FAIL subsec_saturate: got %0d want %0d", s_sub, CLK_FREQ - 1); end
        checks++; if (tick_cnt != t0) begin fails++; $display("FAIL hold_no_tick: got %0d want 0", tick_cnt - t0); end
    endtask

    task automatic test_reset_mid();
        int n, t0, e0; bit ok;
        wait_start(n, ok);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0; en = 1'b0;
        #1;
        checks++; if ({start, sec_valid, sec_tick, vl, err, fault, sec, subsec} !== '0) begin fails++; $display("FAIL async_reset: outputs nonzero want all 0"); end
        m_sec = 0; m_vl = 0; m_valid = 0; m_fault = 0;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        t0 = tick_cnt; e0 = err_cnt;
        @(posedge clk); #1 done = 1'b1; rdata = 8'h42;
        @(posedge clk); #1 done = 1'b0; rdata = 8'hFF;
        repeat (4) @(posedge clk); #1;
        checks++; if (sec !== 6'd0 || sec_valid !== 1'b0 || start !== 1'b0) begin fails++; $display("FAIL late_done: sec %0d valid %b start %b want 0 0 0", sec, sec_valid, start); end
        checks++; if (tick_cnt != t0 || err_cnt != e0) begin fails++; $display("FAIL late_done_pulses: ticks %0d errs %0d want 0 0", tick_cnt - t0, err_cnt - e0); end
    endtask

    task automatic test_random();
        int n; bit ok; logic [7:0] v;
        m_ticks = tick_cnt; m_errs = err_cnt;
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 0) v = 8'($urandom);
            else v = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            wait_start(n, ok);
            checks++; if (!ok) begin fails++; $display("FAIL rand_start[%0d]: got none want start", i); end
            give_done(v);
            checks++; if (s_sec !== 6'(m_sec) || s_valid !== m_valid || s_vl !== 1'(m_vl)) begin fails++; $display("FAIL rand_state[%0d] v=%h: sec %0d valid %b vl %b want %0d %b %0d", i, v, s_sec, s_valid, s_vl, m_sec, m_valid, m_vl); end
            checks++; if (s_tick !== x_tick || s_err !== x_err || s_fault !== m_fault) begin fails++; $display("FAIL rand_pulses[%0d] v=%h: tick %b err %b fault %b want %b %b %b", i, v, s_tick, s_err, s_fault, x_tick, x_err, m_fault); end
            checks++; if (s_sub != s_xsub || tick_cnt != m_ticks || err_cnt != m_errs) begin fails++; $display("FAIL rand_counts[%0d]: subsec %0d ticks %0d errs %0d want %0d %0d %0d", i, s_sub, tick_cnt, err_cnt, s_xsub, m_ticks, m_errs); end
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_seconds();
        test_wrap();
        test_invalid();
        test_timeout();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at 5 ms, want finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pcf8563_time_sync.md
# pcf8563_time_sync

Downstream consumer of the PCF8563 I2C interface in the APDAQ subsystem. Periodically pulses the interface's `start` and captures the returned seconds register byte on `done`. Validates and decodes the BCD and tracks seconds changes. Publishes a timestamp (seconds plus a clock-cycle sub-second count) to the acquisition path.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: clk frequency in Hz; sub-second counter saturates at CLK_FREQ-1
- POLL_CYCLES, 100_000: cycles from end of one read (CHECK) to the next `start`
- TIMEOUT_CYCLES, 1_000_000: max cycles waiting for `done` after `start`
- SUBW, $clog2(CLK_FREQ): sub-second counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable polling
- start  out  1  one-cycle read request to pcf8563 interface
- rdata  in  8  seconds register byte (bit7 VL, bits6:4 BCD tens, bits3:0 BCD units), valid when `done`=1
- done  in  1  one-cycle read-complete pulse from interface
- sec  out  6  decoded seconds, binary 0..59
- subsec  out  SUBW  cycles since last observed seconds change
- sec_valid  out  1  at least one valid sample since reset/enable
- sec_tick  out  1  one-cycle pulse when `sec` changes value
- vl  out  1  VL bit of last valid sample
- err  out  1  one-cycle pulse on invalid BCD or timeout
- fault  out  1  sticky error flag, cleared when `en`=0 in IDLE

## Operation
- FSM states: IDLE, WAIT, REQ, BUSY, CHECK.
- IDLE: counters cleared. If `en`=1, go to WAIT. If `en`=0, clear fault and sec_valid.
- WAIT: poll counter counts 0..POLL_CYCLES-1. At terminal count go to REQ. If `en`=0, go to IDLE.
- REQ: `start`=1 for exactly this cycle. Clear timeout counter. Go to BUSY.
- BUSY: on `done`=1, register rdata and go to CHECK. If the timeout counter reaches TIMEOUT_CYCLES-1 without `done`, pulse err, set fault, and go to WAIT. `en` falling in BUSY does not abort; the exit target becomes IDLE instead of WAIT.
- CHECK (one cycle): tens=rdata[6:4], units=rdata[3:0]. Invalid if tens>5 or units>9. In that case: pulse err, set fault, leave sec/vl/sec_valid unchanged.
  - Valid: value=tens*10+units (6-bit), vl<=rdata[7].
  - sec_valid already 1 and value≠sec: sec_tick=1, subsec cleared.
  - sec_valid was 0: sec loaded, sec_valid<=1, subsec cleared, no sec_tick.
  - Same value: no change.
  - Then go to WAIT (or IDLE if `en`=0).
- `done` outside BUSY is ignored.
- 59→0 is a change (tick); any jump (e.g. 10→13) also ticks with no interpolation.
- subsec increments every cycle while sec_valid=1 and saturates at CLK_FREQ-1. It is cleared on sec_tick, on first valid sample, and in IDLE.
- VL=1 samples are accepted as valid; only `vl` reports them.

## Timing
- Reset values: start=0, sec=0, subsec=0, sec_valid=0, sec_tick=0, vl=0, err=0, fault=0; state IDLE.
- First `start`: POLL_CYCLES+1 cycles after the edge where IDLE sees `en`=1 (IDLE→WAIT edge, POLL_CYCLES WAIT cycles, REQ).
- `done` sampled at edge N. CHECK occupies cycle N+1. sec/sec_tick/err/vl/sec_valid are updated at edge N+2 (registered). sec_tick/err are high for one cycle.
- Next `start` comes POLL_CYCLES+1 cycles after CHECK.
- Timeout err asserts TIMEOUT_CYCLES cycles after the REQ cycle.
- Reset mid-transaction: all outputs return to reset values asynchronously. A late `done` after reset is ignored (state IDLE).
- Timestamp resolution equals the poll period. subsec lags the true RTC edge by up to POLL_CYCLES + transaction length.

## Test plan
Simulation parameters: CLK_FREQ=1000, POLL_CYCLES=100, TIMEOUT_CYCLES=1000; the bench models `done` 20 cycles after `start`.
- Reset release, en=1: first `start` exactly 101 cycles after en seen; all outputs 0 until the first CHECK.
- Reads 0x25, then 0x25, then 0x26: sec=25 with sec_valid=1 and no tick; then no tick; then sec=26 with one sec_tick and subsec=0 on that cycle.
- Reads 0x59, then 0x00: sec 59→0 with sec_tick. Reads 0x85: sec=5, vl=1, sec_valid=1.
- Reads 0x6A and 0x3C: err pulses twice, fault=1, sec holds its previous value; en=0 clears fault in IDLE.
- No `done` after `start`: err exactly 1000 cycles after REQ, fault=1, next `start` 101 cycles later; a stray `done` in WAIT causes no change.
- Hold rdata constant for 2000 cycles: subsec saturates at 999. Assert rst_n=0 mid-BUSY: all outputs 0 immediately and a late `done` is ignored.
